// File: rtl/arb_pkg.sv
// Shared constants and types for the packet arbitrating multiplexer.
//   MODE_FIXED / MODE_RR : values of the arbitration mode input
//   lock_st_e            : packet lock state (unlocked / locked to one channel)
package arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_st_e;

endpackage

// File: rtl/arb_mux_pkt_rr_pick.sv
// Combinational N-way priority picker: returns the first requesting index found
// when searching upward from start_i, wrapping modulo N.
//   req_i   : request vector
//   start_i : index searched first (0 gives plain fixed priority)
//   gnt_o   : one-hot grant
//   idx_o   : binary index of the granted request
//   any_o   : at least one request present
module rr_pick
  import arb_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int unsigned cand;

  // Walk the ring once from start_i; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(start_i) + i) % N;
      if (!any_o && req_i[W'(cand)]) begin
        any_o             = 1'b1;
        gnt_o[W'(cand)]   = 1'b1;
        idx_o             = W'(cand);
      end
    end
  end

endmodule

// File: rtl/arb_mux_pkt.sv
// N-channel arbitrating multiplexer with valid/ready handshake, registered
// output stage, packet locking and a burst watchdog.
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   mode          : 0 fixed priority (ch0 highest), 1 round-robin
//   in_valid      : per-channel beat valid
//   in_last       : per-channel last beat of packet
//   in_data       : flattened data, channel i at [i*DATA_W +: DATA_W]
//   in_ready      : per-channel accept (combinational, at most one bit set)
//   out_valid     : output register holds a beat
//   out_ready     : downstream accept
//   out_data      : registered selected data
//   out_last      : registered last flag
//   out_ch        : registered source channel index
//   burst_cut     : one-cycle pulse when the watchdog forces a lock release
module arb_mux_pkt
  import arb_pkg::*;
#(
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned CH_W      = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH-1:0]          in_last,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  output logic                     burst_cut
);

  localparam int unsigned CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  lock_st_e             st_q, st_d;
  logic [CH_W-1:0]      lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 bubble_q, bubble_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic                 burst_cut_q, burst_cut_d;

  logic                 load_en;
  logic [N_CH-1:0]      lock_mask;
  logic [N_CH-1:0]      req;
  logic [CH_W-1:0]      start;
  logic [N_CH-1:0]      gnt;
  logic [CH_W-1:0]      gidx;
  logic                 gany;
  logic                 xfer;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_last;
  logic [CH_W-1:0]      ptr_nx;
  logic [CNT_W-1:0]     cnt_nx;

  // Request masking: nothing during the post-release bubble, only the owner while locked.
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    lock_mask = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      lock_mask[i] = (lock_ch_q == CH_W'(i));
    end
    if (bubble_q) begin
      req = '0;
    end else if (st_q == ST_LOCKED) begin
      req = in_valid & lock_mask;
    end else begin
      req = in_valid;
    end
    start = (st_q == ST_UNLOCKED && mode == MODE_RR) ? rr_ptr_q : '0;
  end

  rr_pick #(.N(N_CH)) u_pick (
    .req_i   (req),
    .start_i (start),
    .gnt_o   (gnt),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  // Handshake and data select for the granted channel.
  always_comb begin
    in_ready = load_en ? gnt : '0;
    xfer     = load_en && gany;
    sel_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        sel_data = in_data[i*DATA_W +: DATA_W];
      end
    end
    sel_last = |(gnt & in_last);
    ptr_nx   = (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + CH_W'(1);
    cnt_nx   = (st_q == ST_LOCKED) ? cnt_q + CNT_W'(1) : CNT_W'(1);
  end

  // Lock FSM, watchdog and output stage next-state.
  always_comb begin
    st_d        = st_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    bubble_d    = 1'b0;
    burst_cut_d = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    if (load_en) begin
      out_valid_d = xfer;
    end

    if (xfer) begin
      out_data_d = sel_data;
      out_last_d = sel_last;
      out_ch_d   = gidx;
      if (sel_last) begin
        // Packet end; a single-beat packet never locks, so no bubble for it.
        bubble_d = (st_q == ST_LOCKED);
        st_d     = ST_UNLOCKED;
        cnt_d    = '0;
        rr_ptr_d = ptr_nx;
      end else if (MAX_BURST != 0 && cnt_nx == CNT_W'(MAX_BURST)) begin
        // Watchdog release: rest of the packet re-arbitrates as a new packet.
        bubble_d    = 1'b1;
        burst_cut_d = 1'b1;
        st_d        = ST_UNLOCKED;
        cnt_d       = '0;
        rr_ptr_d    = ptr_nx;
      end else begin
        st_d      = ST_LOCKED;
        lock_ch_d = gidx;
        cnt_d     = cnt_nx;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= ST_UNLOCKED;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      bubble_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      burst_cut_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      bubble_q    <= bubble_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      burst_cut_q <= burst_cut_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign burst_cut = burst_cut_q;

endmodule

// File: tb/tb_arb_mux_pkt.sv
// Self-checking bench for arb_mux_pkt (4 channels, 8-bit data, MAX_BURST=4).
module tb_arb_mux_pkt;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXB = 4;

  logic         clk;
  logic         rst;
  logic         mode;
  logic [3:0]   in_valid;
  logic [3:0]   in_last;
  logic [31:0]  in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic [1:0]   out_ch;
  logic         burst_cut;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, expressed as packet-level facts.
  bit         m_locked;
  int         m_owner;
  int         m_rr;
  int         m_beats;
  bit         m_gap;
  bit         m_cut;
  logic       m_ov;
  logic [7:0] m_od;
  logic       m_ol;
  int         m_och;

  int         rr_seq [6];

  arb_mux_pkt #(.N_CH(N), .DATA_W(W), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .burst_cut (burst_cut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_gap = 0; m_cut = 0;
    m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_och = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 4'b0; in_last = 4'b0; in_data = 32'h0; out_ready = 1'b1; mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait until just after the next rising edge (registered outputs updated).
  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  // One cycle: check registered outputs, drive inputs, check in_ready, advance the model.
  task automatic step(input logic md, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic rdy);
    int         g;
    int         c;
    int         base;
    int         beats;
    logic       ld;
    bit         nxt_gap;
    logic [3:0] exp_rdy;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  32'(out_data),  32'(m_od));
    chk("out_last",  32'(out_last),  32'(m_ol));
    chk("out_ch",    32'(out_ch),    32'(m_och));
    chk("burst_cut", 32'(burst_cut), 32'(m_cut));
    mode = md; in_valid = v; in_last = l; in_data = d; out_ready = rdy;
    #1;
    ld = !m_ov || rdy;
    g  = -1;
    if (ld && !m_gap) begin
      if (m_locked) begin
        if (v[2'(m_owner)]) g = m_owner;
      end else begin
        base = md ? m_rr : 0;
        for (int off = 0; off < N; off++) begin
          c = (base + off) % N;
          if (g < 0 && v[2'(c)]) g = c;
        end
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    m_cut   = 0;
    nxt_gap = 0;
    if (ld) m_ov = (g >= 0);
    if (g >= 0) begin
      m_od  = d[g*8 +: 8];
      m_ol  = l[2'(g)];
      m_och = g;
      beats = m_locked ? m_beats + 1 : 1;
      if (l[2'(g)]) begin
        nxt_gap = m_locked; m_locked = 0; m_beats = 0; m_rr = (g + 1) % N;
      end else if (MAXB != 0 && beats == MAXB) begin
        m_cut = 1; nxt_gap = 1; m_locked = 0; m_beats = 0; m_rr = (g + 1) % N;
      end else begin
        m_locked = 1; m_owner = g; m_beats = beats;
      end
    end
    m_gap = nxt_gap;
  endtask

  initial begin
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic [31:0] rd;
    logic        rm;
    logic        rrdy;

    rst = 1'b0; mode = 1'b0; in_valid = 4'b0; in_last = 4'b0; in_data = 32'h0; out_ready = 1'b1;
    model_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_burst_cut", 32'(burst_cut), 32'd0);
    do_reset();

    // Fixed priority: ch1 beats ch3; ch3 only after ch1 drops.
    step(1'b0, 4'b1010, 4'b1111, 32'h33_00_11_00, 1'b1);
    chk("fix_rdy1", 32'(in_ready), 32'h2);
    peek();
    chk("fix_ch1",   32'(out_ch),   32'd1);
    chk("fix_data1", 32'(out_data), 32'h11);
    step(1'b0, 4'b1000, 4'b1111, 32'h33_00_11_00, 1'b1);
    chk("fix_rdy3", 32'(in_ready), 32'h8);
    peek();
    chk("fix_ch3",   32'(out_ch),   32'd3);
    chk("fix_data3", 32'(out_data), 32'h33);

    // Round-robin over four always-valid single-beat channels.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'b1111, 4'b1111, 32'h44_33_22_11, 1'b1);
      peek();
      rr_seq[i] = int'(out_ch);
    end
    chk("rr_seq0", 32'(rr_seq[0]), 32'd0);
    chk("rr_seq1", 32'(rr_seq[1]), 32'd1);
    chk("rr_seq2", 32'(rr_seq[2]), 32'd2);
    chk("rr_seq3", 32'(rr_seq[3]), 32'd3);
    chk("rr_seq4", 32'(rr_seq[4]), 32'd0);
    chk("rr_seq5", 32'(rr_seq[5]), 32'd1);

    // Packet lock: ch2 keeps the grant for 3 beats though ch0 rises mid-packet.
    do_reset();
    step(1'b0, 4'b0100, 4'b0000, 32'h00_A1_00_00, 1'b1);
    chk("lock_rdy1", 32'(in_ready), 32'h4);
    step(1'b0, 4'b0101, 4'b0000, 32'h00_A2_00_0F, 1'b1);
    chk("lock_rdy2", 32'(in_ready), 32'h4);
    step(1'b0, 4'b0101, 4'b0100, 32'h00_A3_00_0F, 1'b1);
    chk("lock_rdy3", 32'(in_ready), 32'h4);
    peek();
    chk("lock_ch3", 32'(out_ch), 32'd2);
    step(1'b0, 4'b0001, 4'b0001, 32'h00_00_00_0F, 1'b1);
    chk("lock_bubble", 32'(in_ready), 32'h0);
    step(1'b0, 4'b0001, 4'b0001, 32'h00_00_00_0F, 1'b1);
    chk("lock_ch0_rdy", 32'(in_ready), 32'h1);

    // Backpressure: output held five cycles, then the waiting beat moves exactly once.
    do_reset();
    step(1'b0, 4'b0001, 4'b0001, 32'h0000_00AA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0001, 4'b0001, 32'h0000_00BB, 1'b0);
      chk("bp_rdy", 32'(in_ready), 32'h0);
      peek();
      chk("bp_hold", 32'(out_data), 32'hAA);
    end
    step(1'b0, 4'b0001, 4'b0001, 32'h0000_00BB, 1'b1);
    peek();
    chk("bp_resume", 32'(out_data), 32'hBB);
    step(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);

    // Watchdog: fourth non-last ch1 beat forces a release; ch3 wins after the bubble.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b1010, 4'b0000, 32'h30_00_10_00 | 32'(i << 8), 1'b1);
      chk("wd_rdy_ch1", 32'(in_ready), 32'h2);
    end
    peek();
    chk("wd_cut", 32'(burst_cut), 32'd1);
    chk("wd_model_rr", 32'(m_rr), 32'd2);
    step(1'b1, 4'b1010, 4'b0000, 32'h30_00_15_00, 1'b1);
    chk("wd_bubble", 32'(in_ready), 32'h0);
    step(1'b1, 4'b1010, 4'b0000, 32'h30_00_15_00, 1'b1);
    chk("wd_ch3", 32'(in_ready), 32'h8);

    // Reset while locked to ch2 with a beat in the output register.
    do_reset();
    step(1'b0, 4'b0100, 4'b0000, 32'h00_5A_00_00, 1'b1);
    peek();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_async_clear", 32'(out_valid), 32'd0);
    model_reset();
    in_valid = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 4'b0110, 4'b0110, 32'h00_22_11_00, 1'b1);
    chk("mid_rr_ch1", 32'(in_ready), 32'h2);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rm   = (((cyc / 250) % 2) == 1) ? 1'b1 : 1'b0;
      rv   = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < N; i++) rl[i] = ($urandom_range(0, 2) == 0);
      rd   = $urandom;
      rrdy = ($urandom_range(0, 3) != 0);
      step(rm, rv, rl, rd, rrdy);
    end
    @(negedge clk);
    chk("final_out_valid", 32'(out_valid), 32'(m_ov));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arb_mux_pkt.md
Name: arb_mux_pkt

Overview:
- Parametrised N-channel arbitrating multiplexer; successor to the 4-input fixed/round-robin mux.
- Adds per-channel valid/ready handshake, a registered output stage and packet locking.
- Adds a burst watchdog so a long packet cannot starve other channels.
- Sits between multiple requesters and a single shared downstream consumer.

Parameters:
- N_CH, 4, number of input channels (>= 2).
- DATA_W, 8, data width per channel.
- MAX_BURST, 16, max beats held under one lock before forced release; 0 disables the watchdog.
- CH_W, $clog2(N_CH), derived channel-index width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = fixed priority (ch0 highest); 1 = round-robin.
- in_valid  in  N_CH  per-channel request valid.
- in_last  in  N_CH  per-channel last beat of packet.
- in_data  in  N_CH*DATA_W  flattened data; channel i at [i*DATA_W +: DATA_W].
- in_ready  out  N_CH  per-channel accept, combinational.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  registered selected data.
- out_last  out  1  registered last flag.
- out_ch  out  CH_W  registered source channel index.
- burst_cut  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (rst=0, async): out_valid=0, out_data=0, out_last=0, out_ch=0, burst_cut=0; rr_ptr=0; lock cleared; beat counter=0.
- load_en = !out_valid || out_ready. An input beat transfers on channel i when in_valid[i] && in_ready[i].
- Grant selection, when unlocked:
  - mode 0: lowest-index valid channel.
  - mode 1: first valid channel searching from rr_ptr upward, wrapping modulo N_CH.
- Grant when locked to k: channel k only. Other valids are ignored even if higher priority.
- in_ready[i] = load_en && (grant == i). At most one bit is set. All bits are 0 when no valid or !load_en.
- Latency: a beat accepted in cycle t appears on out_* at t+1. Full throughput is 1 beat/cycle while out_ready=1.
- Output hold: if out_valid && !out_ready, out_* are held stable and no input is accepted.
- State machine:
  - UNLOCKED to LOCKED(k): on transfer from channel k with in_last=0.
  - LOCKED(k) to UNLOCKED: on transfer from k with in_last=1, or on watchdog release.
  - Single-beat packet (in_last=1 on the first beat): stays UNLOCKED.
- Locked channel drops in_valid: no transfer, lock retained indefinitely (unless the watchdog fires).
- rr_ptr update:
  - Set to (k+1) mod N_CH on the packet-ending transfer from k, in either mode.
  - Also set to (k+1) mod N_CH on watchdog release.
  - Not changed mid-packet.
- mode is sampled only for unlocked arbitration. A mode change mid-packet takes effect after release.
- Watchdog (MAX_BURST>0):
  - Beat counter increments on each transfer while locked or locking; it is cleared on release.
  - When a non-last transfer makes the count equal MAX_BURST: release the lock, advance rr_ptr, pulse burst_cut for 1 cycle.
  - The remainder of that packet re-arbitrates like a new packet.
- Simultaneous events: a packet-end transfer and new arbitration occur in the same cycle only via combinational grant; the new grant is used on the next cycle. A one-cycle arbitration bubble after release is permitted and required.
- Reset mid-packet: lock, counter and rr_ptr are cleared; any output beat in flight is dropped.

Decomposition:
- Shared package arb_pkg:
  - Mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Lock-state enum {ST_UNLOCKED, ST_LOCKED}.
- Sub-module rr_pick: combinational N_CH priority picker.
  - Inputs: req vector, start index.
  - Outputs: one-hot grant, index, any.
  - Used for both modes: start=0 in fixed mode.

Test Plan:
- Fixed priority: mode=0, in_valid=4'b1010 with data ch1=0x11, ch3=0x33, all last=1, out_ready=1 -> out_ch=1, out_data=0x11 one cycle after in_ready[1]=1; ch3 served only after ch1 deasserts valid.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, all last=1, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 over consecutive grants (arbitration bubbles allowed).
- Packet lock: mode=0, ch2 sends 3 beats (last on the 3rd) while ch0 raises valid at beat 2 -> out_ch=2 for all 3 beats, then ch0 is granted.
- Backpressure: out_ready=0 with out_valid=1 for 5 cycles -> out_data stable, in_ready=0 for all channels; on out_ready=1 transfer resumes with no lost or duplicated beat.
- Watchdog: MAX_BURST=4, ch1 streams with last=0, ch3 valid, mode=1 -> burst_cut pulses after the 4th ch1 beat, rr_ptr=2, ch3 granted next.
- Reset mid-packet: assert rst=0 while LOCKED(2) with out_valid=1 -> out_valid=0 immediately (async); after release, in_valid=4'b0110 in mode 1 grants ch1 (rr_ptr=0).
